// File: rtl/enemy_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_spawner
//  Description : Control stage ahead of the Enemy sprite. Chooses when an
//                enemy car enters the road and in which lane, retires it on
//                exit or collision, runs a frame-tick cooldown and respawns.
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_spawner #(
    parameter int          ROAD_LEFT  = 129,
    parameter int          LANE_WIDTH = 96,
    parameter int          SPAWN_Y    = 0,
    parameter int          EXIT_Y     = 480,
    parameter int          COOLDOWN   = 60,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] enemy_pos_y,
    input  logic       collision,
    output logic       enemy_load,
    output logic       enemy_enable,
    output logic [9:0] offset_x,
    output logic [9:0] offset_y,
    output logic [7:0] spawn_count,
    output logic       halted
);

    localparam int              c_CNT_W     = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_COOL_LOAD = c_CNT_W'(COOLDOWN);
    localparam logic [15:0]     c_LFSR_MASK = 16'hB400;
    // An all-zero Galois LFSR never leaves zero, so a zero seed becomes 1.
    localparam logic [15:0]     c_SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_SPAWN  = 3'd1;
    localparam logic [2:0] c_S_ACTIVE = 3'd2;
    localparam logic [2:0] c_S_COOL   = 3'd3;
    localparam logic [2:0] c_S_HALT   = 3'd4;

    logic [2:0]         r_state;
    logic [15:0]        r_lfsr;
    logic [1:0]         r_last_lane;
    logic [c_CNT_W-1:0] r_cool_cnt;

    logic [2:0]  w_next_state;
    logic [15:0] w_lfsr_next;
    logic [1:0]  w_cand;
    logic [1:0]  w_lane;
    logic [9:0]  w_offset_x;
    logic        w_exit;

    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_LFSR_MASK : 16'h0000);
    assign w_cand      = r_lfsr[1:0];
    // Bumping a repeated candidate by one lane (mod 4) guarantees a new lane.
    assign w_lane      = (w_cand == r_last_lane) ? (w_cand + 2'd1) : w_cand;
    assign w_offset_x  = 10'(ROAD_LEFT) + (10'(w_lane) * 10'(LANE_WIDTH));
    assign w_exit      = (32'(enemy_pos_y) >= $unsigned(EXIT_Y));

    // Next-state selection; collision outranks exit inside ACTIVE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start) w_next_state = c_S_SPAWN;
            end
            c_S_SPAWN: begin
                w_next_state = c_S_ACTIVE;
            end
            c_S_ACTIVE: begin
                if (!start)         w_next_state = c_S_IDLE;
                else if (collision) w_next_state = c_S_HALT;
                else if (w_exit)    w_next_state = c_S_COOL;
            end
            c_S_COOL: begin
                if (!start)                 w_next_state = c_S_IDLE;
                else if (r_cool_cnt == '0)  w_next_state = c_S_SPAWN;
            end
            c_S_HALT: begin
                if (!start) w_next_state = c_S_IDLE;
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    // State, LFSR, cooldown counter, lane choice and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_S_IDLE;
            r_lfsr       <= c_SEED;
            r_last_lane  <= 2'd3;
            r_cool_cnt   <= '0;
            enemy_load   <= 1'b0;
            enemy_enable <= 1'b0;
            halted       <= 1'b0;
            offset_x     <= 10'(ROAD_LEFT);
            offset_y     <= 10'(SPAWN_Y);
            spawn_count  <= 8'd0;
        end else begin
            r_state      <= w_next_state;
            r_lfsr       <= w_lfsr_next;
            enemy_load   <= (w_next_state == c_S_SPAWN);
            enemy_enable <= (w_next_state == c_S_ACTIVE);
            halted       <= (w_next_state == c_S_HALT);

            // SPAWN never follows itself, so this fires only on SPAWN entry.
            if (w_next_state == c_S_SPAWN) begin
                offset_x    <= w_offset_x;
                offset_y    <= 10'(SPAWN_Y);
                r_last_lane <= w_lane;
                if (spawn_count != 8'hFF) spawn_count <= spawn_count + 8'd1;
            end

            if ((r_state == c_S_ACTIVE) && (w_next_state == c_S_COOL)) begin
                r_cool_cnt <= c_COOL_LOAD;
            end else if ((r_state == c_S_COOL) && start && (r_cool_cnt != '0) && tick) begin
                r_cool_cnt <= r_cool_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
